// File: rtl/instr_buffer.sv
// instr_buffer: two-wide in-order instruction FIFO between fetch and decode.
// Define IB_PMU_EN to enable the full-cycle performance counter.
module instr_buffer #(
  parameter int DEPTH       = 8,
  parameter int ENTRY_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [1:0]               fetch_valid_i,
  input  logic [2*ENTRY_WIDTH-1:0] fetch_data_i,
  output logic                     fetch_ready_o,
  output logic [1:0]               id_valid_o,
  output logic [2*ENTRY_WIDTH-1:0] id_data_o,
  input  logic [1:0]               ib_accept_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [31:0]              pmu_full_cycles_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [ENTRY_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [1:0] n_push, n_pop;
  logic pop0, pop1;
  logic [ENTRY_WIDTH-1:0] wd0, wd1;
  // Readiness is taken from the registered count only, so a same-cycle pop never helps
  assign fetch_ready_o = count <= CW'(DEPTH - 2);
  assign id_valid_o    = {count >= CW'(2), count != '0};
  assign id_data_o     = {mem[head + AW'(1)], mem[head]};
  assign count_o       = count;
  always_comb begin
    n_push = (fetch_ready_o && !flush) ? {1'b0, fetch_valid_i[0]} + {1'b0, fetch_valid_i[1]} : 2'd0;
    wd0    = fetch_valid_i[0] ? fetch_data_i[ENTRY_WIDTH-1:0] : fetch_data_i[2*ENTRY_WIDTH-1:ENTRY_WIDTH];
    wd1    = fetch_data_i[2*ENTRY_WIDTH-1:ENTRY_WIDTH];
    pop0   = ib_accept_i[0] & id_valid_o[0];
    pop1   = pop0 & ib_accept_i[1] & id_valid_o[1];
    n_pop  = {1'b0, pop0} + {1'b0, pop1};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(n_pop);
      tail  <= tail + AW'(n_push);
      count <= count + CW'(n_push) - CW'(n_pop);
    end
  always_ff @(posedge clk) begin
    if (n_push != 2'd0) mem[tail] <= wd0;
    if (n_push == 2'd2) mem[tail + AW'(1)] <= wd1;
  end
`ifdef IB_PMU_EN
  logic [31:0] pmu;
  always_ff @(posedge clk or posedge rst)
    if (rst) pmu <= '0;
    else if (count == CW'(DEPTH) && !flush && pmu != '1) pmu <= pmu + 32'd1;
  assign pmu_full_cycles_o = pmu;
`else
  assign pmu_full_cycles_o = '0;
`endif
endmodule

// File: tb/tb_instr_buffer.sv
// tb_instr_buffer: randomized checks of instr_buffer against a queue-based reference model.
module tb_instr_buffer;
  localparam int DEPTH = 8;
  localparam int W = 64;
  logic clk = 1'b0;
  logic rst, flush, fetch_ready_o;
  logic [1:0] fetch_valid_i, ib_accept_i, id_valid_o;
  logic [2*W-1:0] fetch_data_i, id_data_o;
  logic [3:0] count_o;
  logic [31:0] pmu_full_cycles_o;
  logic [W-1:0] q[$];
  int pmu_m, passed, total;

  always #5 clk = ~clk;

  instr_buffer #(.DEPTH(DEPTH), .ENTRY_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fetch_valid_i(fetch_valid_i), .fetch_data_i(fetch_data_i), .fetch_ready_o(fetch_ready_o),
    .id_valid_o(id_valid_o), .id_data_o(id_data_o), .ib_accept_i(ib_accept_i),
    .count_o(count_o), .pmu_full_cycles_o(pmu_full_cycles_o)
  );

  function automatic logic [W-1:0] ent(input logic [31:0] pc);
    return {$urandom(), pc};
  endfunction

  function automatic logic [31:0] pmu_exp();
`ifdef IB_PMU_EN
    return pmu_m;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [1:0] exp_valid();
    return {q.size() >= 2, q.size() >= 1};
  endfunction

  // Applies one cycle of stimulus and advances the queue model by the same rules.
  task automatic drive(input logic [1:0] fv, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] acc, input logic fl);
    int n = q.size();
    bit rdy = n <= DEPTH - 2;
    fetch_valid_i = fv; fetch_data_i = {b, a}; ib_accept_i = acc; flush = fl;
    if (n == DEPTH && !fl) pmu_m++;
    if (fl) q.delete();
    else begin
      if (acc[0] && n >= 1) begin
        void'(q.pop_front());
        if (acc[1] && n >= 2) void'(q.pop_front());
      end
      if (rdy && fv[0]) q.push_back(a);
      if (rdy && fv == 2'b11) q.push_back(b);
    end
    @(posedge clk); #1;
    fetch_valid_i = '0; ib_accept_i = '0; flush = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    pmu_m = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; fetch_valid_i = '0; ib_accept_i = '0; fetch_data_i = '0;
    #7;
    total++; if (count_o !== 4'd0) $display("FAIL reset_count got %0d exp 0", count_o); else passed++;
    total++; if (id_valid_o !== 2'b00) $display("FAIL reset_valid got %b exp 00", id_valid_o); else passed++;
    total++; if (fetch_ready_o !== 1'b1) $display("FAIL reset_ready got %b exp 1", fetch_ready_o); else passed++;
    total++; if (pmu_full_cycles_o !== 32'd0) $display("FAIL reset_pmu got %0d exp 0", pmu_full_cycles_o); else passed++;
    @(posedge clk); #1;
    rst = 1'b0; q.delete(); pmu_m = 0;
  endtask

  task automatic test_push_pop();
    logic [W-1:0] a = ent(32'h100), b = ent(32'h104), c = ent(32'h108), d = ent(32'h10c), e = ent(32'h110);
    do_reset();
    drive(2'b11, a, b, 2'b00, 1'b0);
    total++; if (id_valid_o !== 2'b11) $display("FAIL pair_valid got %b exp 11", id_valid_o); else passed++;
    total++; if (id_data_o !== {b, a}) $display("FAIL pair_data got %h exp %h", id_data_o, {b, a}); else passed++;
    total++; if (count_o !== 4'd2) $display("FAIL pair_count got %0d exp 2", count_o); else passed++;
    drive(2'b01, c, '0, 2'b00, 1'b0);
    drive(2'b11, d, e, 2'b01, 1'b0);
    total++; if (count_o !== 4'd4) $display("FAIL partial_count got %0d exp 4", count_o); else passed++;
    total++; if (id_data_o !== {c, b}) $display("FAIL partial_data got %h exp %h", id_data_o, {c, b}); else passed++;
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(2'b11, ent(1), ent(2), 2'b00, 1'b0);
    drive(2'b11, ent(3), ent(4), 2'b00, 1'b0);
    #2 rst = 1'b1;
    #1;
    total++; if (count_o !== 4'd0) $display("FAIL async_rst_count got %0d exp 0", count_o); else passed++;
    total++; if (id_valid_o !== 2'b00) $display("FAIL async_rst_valid got %b exp 00", id_valid_o); else passed++;
    @(posedge clk); #1;
    rst = 1'b0; q.delete(); pmu_m = 0;
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 3; i++) drive(2'b11, ent(32'(8 * i)), ent(32'(8 * i + 4)), 2'b00, 1'b0);
    total++; if (fetch_ready_o !== 1'b1) $display("FAIL bp6_ready got %b exp 1", fetch_ready_o); else passed++;
    drive(2'b01, ent(32'h30), '0, 2'b00, 1'b0);
    total++; if (fetch_ready_o !== 1'b0) $display("FAIL bp7_ready got %b exp 0", fetch_ready_o); else passed++;
    drive(2'b11, ent(32'hdead0), ent(32'hdead4), 2'b00, 1'b0);
    total++; if (count_o !== 4'(q.size())) $display("FAIL bp_ignored_count got %0d exp %0d", count_o, q.size()); else passed++;
    total++; if (id_data_o !== {q[1], q[0]}) $display("FAIL bp_heads got %h exp %h", id_data_o, {q[1], q[0]}); else passed++;
    drive(2'b11, ent(32'hbeef0), ent(32'hbeef4), 2'b11, 1'b0);
    total++; if (count_o !== 4'(q.size())) $display("FAIL bp_conservative_count got %0d exp %0d", count_o, q.size()); else passed++;
    drive(2'b00, '0, '0, 2'b11, 1'b0);
    total++; if (count_o !== 4'(q.size())) $display("FAIL bp_pop_count got %0d exp %0d", count_o, q.size()); else passed++;
    total++; if (fetch_ready_o !== 1'b1) $display("FAIL bp_pop_ready got %b exp 1", fetch_ready_o); else passed++;
  endtask

  task automatic test_wrap();
    logic [31:0] got[$];
    logic [1:0] fv, acc;
    int ni = 0;
    do_reset();
    for (int c = 0; c < 200 && got.size() < 20; c++) begin
      fv = (ni <= 18) ? 2'b11 : (ni == 19 ? 2'b01 : 2'b00);
      acc = 2'($urandom_range(0, 3));
      if (acc[0] && id_valid_o[0]) begin
        got.push_back(id_data_o[31:0]);
        if (acc[1] && id_valid_o[1]) got.push_back(id_data_o[W+31:W]);
      end
      if (q.size() <= DEPTH - 2) ni += (fv == 2'b11) ? 2 : (fv == 2'b01 ? 1 : 0);
      drive(fv, ent(32'h1c000000 + 32'(4 * ni - 4 * ((fv == 2'b11) ? 2 : (fv == 2'b01 ? 1 : 0)) * int'(q.size() >= 0) * 0 + 0)), '0, acc, 1'b0);
    end
  endtask

  task automatic test_wrap_order();
    logic [31:0] got[$];
    logic [1:0] fv, acc;
    int ni = 0;
    do_reset();
    for (int c = 0; c < 300 && got.size() < 20; c++) begin
      fv = (ni <= 18) ? 2'b11 : (ni == 19 ? 2'b01 : 2'b00);
      acc = 2'($urandom_range(0, 3));
      if (acc[0] && id_valid_o[0]) begin
        got.push_back(id_data_o[31:0]);
        if (acc[1] && id_valid_o[1]) got.push_back(id_data_o[W+31:W]);
      end
      if (q.size() <= DEPTH - 2) begin
        drive(fv, ent(32'h1c000000 + 32'(4 * ni)), ent(32'h1c000000 + 32'(4 * ni + 4)), acc, 1'b0);
        ni += (fv == 2'b11) ? 2 : (fv == 2'b01 ? 1 : 0);
      end else drive(fv, ent(32'hbad0), ent(32'hbad4), acc, 1'b0);
      total++; if (count_o !== 4'(q.size())) $display("FAIL wrap_count cyc %0d got %0d exp %0d", c, count_o, q.size()); else passed++;
    end
    total++; if (got.size() !== 20) $display("FAIL wrap_pop_total got %0d exp 20", got.size()); else passed++;
    for (int i = 0; i < got.size() && i < 20; i++) begin
      total++;
      if (got[i] !== 32'h1c000000 + 32'(4 * i)) $display("FAIL wrap_order idx %0d got %h exp %h", i, got[i], 32'h1c000000 + 32'(4 * i));
      else passed++;
    end
  endtask

  task automatic test_flush();
    logic [W-1:0] p = ent(32'h5000), r = ent(32'h5004), n = ent(32'h6000);
    do_reset();
    for (int i = 0; i < 3; i++) drive(2'b11, ent(32'(16 * i)), ent(32'(16 * i + 4)), 2'b00, 1'b0);
    drive(2'b11, p, r, 2'b11, 1'b1);
    total++; if (count_o !== 4'd0) $display("FAIL flush_count got %0d exp 0", count_o); else passed++;
    total++; if (id_valid_o !== 2'b00) $display("FAIL flush_valid got %b exp 00", id_valid_o); else passed++;
    total++; if (fetch_ready_o !== 1'b1) $display("FAIL flush_ready got %b exp 1", fetch_ready_o); else passed++;
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, '0, '0, 2'b11, 1'b0);
      total++; if (id_valid_o !== 2'b00) $display("FAIL flush_idle_valid cyc %0d got %b exp 00", i, id_valid_o); else passed++;
    end
    drive(2'b01, n, '0, 2'b00, 1'b0);
    total++; if (id_data_o[W-1:0] !== n) $display("FAIL flush_new_head got %h exp %h", id_data_o[W-1:0], n); else passed++;
  endtask

  task automatic test_pmu();
    do_reset();
    for (int i = 0; i < 4; i++) drive(2'b11, ent(32'(8 * i)), ent(32'(8 * i + 4)), 2'b00, 1'b0);
    total++; if (count_o !== 4'd8) $display("FAIL pmu_full_count got %0d exp 8", count_o); else passed++;
    total++; if (fetch_ready_o !== 1'b0) $display("FAIL pmu_full_ready got %b exp 0", fetch_ready_o); else passed++;
    for (int i = 0; i < 5; i++) drive(2'b11, ent(1), ent(2), 2'b00, 1'b0);
    total++; if (pmu_full_cycles_o !== pmu_exp()) $display("FAIL pmu_held got %0d exp %0d", pmu_full_cycles_o, pmu_exp()); else passed++;
    drive(2'b00, '0, '0, 2'b00, 1'b1);
    drive(2'b00, '0, '0, 2'b00, 1'b0);
    total++; if (pmu_full_cycles_o !== pmu_exp()) $display("FAIL pmu_after_flush got %0d exp %0d", pmu_full_cycles_o, pmu_exp()); else passed++;
  endtask

  task automatic test_random();
    logic [1:0] fv, ev;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      fv = ($urandom_range(0, 2) == 0) ? 2'b00 : ($urandom_range(0, 1) ? 2'b01 : 2'b11);
      drive(fv, ent($urandom()), ent($urandom()), 2'($urandom_range(0, 3)), $urandom_range(0, 31) == 0);
      ev = exp_valid();
      total++; if (count_o !== 4'(q.size())) $display("FAIL rand_count cyc %0d got %0d exp %0d", c, count_o, q.size()); else passed++;
      total++; if (id_valid_o !== ev) $display("FAIL rand_valid cyc %0d got %b exp %b", c, id_valid_o, ev); else passed++;
      total++; if (fetch_ready_o !== (q.size() <= DEPTH - 2)) $display("FAIL rand_ready cyc %0d got %b", c, fetch_ready_o); else passed++;
      if (ev[0]) begin
        total++; if (id_data_o[W-1:0] !== q[0]) $display("FAIL rand_head0 cyc %0d got %h exp %h", c, id_data_o[W-1:0], q[0]); else passed++;
      end
      if (ev[1]) begin
        total++; if (id_data_o[2*W-1:W] !== q[1]) $display("FAIL rand_head1 cyc %0d got %h exp %h", c, id_data_o[2*W-1:W], q[1]); else passed++;
      end
      total++; if (pmu_full_cycles_o !== pmu_exp()) $display("FAIL rand_pmu cyc %0d got %0d exp %0d", c, pmu_full_cycles_o, pmu_exp()); else passed++;
    end
  endtask

  initial begin
    passed = 0; total = 0; pmu_m = 0;
    test_reset();
    test_push_pop();
    test_async_reset();
    test_backpressure();
    test_wrap_order();
    test_flush();
    test_pmu();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
